// File: rtl/ev21g1_pkg.sv
// Shared definitions for the ev21g1 issue path: microinstruction field layout,
// ALU opcodes, the NOP encoding and small decode helpers.
package ev21g1_pkg;

  localparam int UINST_W = 30;
  localparam int K_W     = 16;
  localparam int REG_W   = 6;

  localparam int ALUC_MSB  = 29;
  localparam int ALUC_LSB  = 26;
  localparam int SH_MSB    = 25;
  localparam int SH_LSB    = 23;
  localparam int KMX_BIT   = 22;
  localparam int READ_BIT  = 21;
  localparam int WRITE_BIT = 20;
  localparam int A_MSB     = 19;
  localparam int A_LSB     = 14;
  localparam int B_MSB     = 13;
  localparam int B_LSB     = 8;
  localparam int C_MSB     = 7;
  localparam int C_LSB     = 2;
  localparam int FLIP_BIT  = 1;
  localparam int PRINT_BIT = 0;

  localparam logic [3:0] ALU_PASS = 4'b0000;
  localparam logic [3:0] ALU_MOV  = 4'b0001;
  localparam logic [3:0] ALU_NOT  = 4'b0011;
  localparam logic [3:0] ALU_ADD  = 4'b0100;
  localparam logic [3:0] ALU_ADC  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_CLC  = 4'b1011;
  localparam logic [3:0] ALU_STC  = 4'b1100;

  // Register index 63 in the c field means "no destination".
  localparam logic [REG_W-1:0] NO_DEST = 6'd63;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  function automatic logic [UINST_W-1:0] pack_uinst(
    input logic [3:0]       aluc,
    input logic [2:0]       sh,
    input logic             kmx,
    input logic             rd,
    input logic             wr,
    input logic [REG_W-1:0] a,
    input logic [REG_W-1:0] b,
    input logic [REG_W-1:0] c,
    input logic             flip,
    input logic             prt
  );
    logic [UINST_W-1:0] w;
    w                    = '0;
    w[ALUC_MSB:ALUC_LSB] = aluc;
    w[SH_MSB:SH_LSB]     = sh;
    w[KMX_BIT]           = kmx;
    w[READ_BIT]          = rd;
    w[WRITE_BIT]         = wr;
    w[A_MSB:A_LSB]       = a;
    w[B_MSB:B_LSB]       = b;
    w[C_MSB:C_LSB]       = c;
    w[FLIP_BIT]          = flip;
    w[PRINT_BIT]         = prt;
    return w;
  endfunction

  localparam logic [UINST_W-1:0] NOP_WORD =
    pack_uinst(ALU_PASS, 3'b000, 1'b0, 1'b0, 1'b0, '0, '0, NO_DEST, 1'b0, 1'b0);

  // A memory read into a real register is a register write; only c decides.
  function automatic logic has_dest(input logic [UINST_W-1:0] u);
    return u[C_MSB:C_LSB] != NO_DEST;
  endfunction

  function automatic logic reads_a(input logic [UINST_W-1:0] u);
    logic [3:0] op;
    op = u[ALUC_MSB:ALUC_LSB];
    return !u[KMX_BIT] && (op != ALU_CLC) && (op != ALU_STC);
  endfunction

  function automatic logic reads_b(input logic [UINST_W-1:0] u);
    logic used;
    case (u[ALUC_MSB:ALUC_LSB])
      ALU_MOV, ALU_NOT, ALU_ADD, ALU_ADC, ALU_OR, ALU_AND: used = 1'b1;
      default:                                             used = 1'b0;
    endcase
    return used;
  endfunction

endpackage

// File: rtl/ev21g1_scoreboard.sv
// In-flight destination tracker: a shift register of recently issued dests and
// the read-after-write compare against the candidate instruction's sources.
module ev21g1_scoreboard
  import ev21g1_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid_i,
  input  logic [REG_W-1:0] load_dest_i,
  input  logic [REG_W-1:0] src_a_i,
  input  logic             a_used_i,
  input  logic [REG_W-1:0] src_b_i,
  input  logic             b_used_i,
  output logic             hazard_o,
  output logic             empty_o,
  output logic             empty_next_o
);

  logic [DEPTH-1:0] valid_q;
  logic [REG_W-1:0] dest_q [DEPTH];

  // NOTE: non-blocking assignments let every entry take its neighbour's pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= load_valid_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  // NOTE: dest fields carry no reset; a stale dest is harmless because valid_q gates every use.
  always_ff @(posedge clk) begin
    dest_q[0] <= load_dest_i;
    for (int i = 1; i < DEPTH; i++) begin
      dest_q[i] <= dest_q[i-1];
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    hazard_o     = 1'b0;
    empty_o      = 1'b1;
    empty_next_o = !load_valid_i;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        empty_o = 1'b0;
        // The oldest entry falls off at the next edge.
        if (i < DEPTH - 1) empty_next_o = 1'b0;
        if ((a_used_i && (src_a_i == dest_q[i])) ||
            (b_used_i && (src_b_i == dest_q[i]))) begin
          hazard_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ev21g1_issue_ctrl.sv
// ev21g1 issue controller: forwards microinstructions to the datapath, inserting
// NOP bubbles on read-after-write hazards and sequencing drain requests.
module ev21g1_issue_ctrl
  import ev21g1_pkg::*;
#(
  parameter int HAZARD_DEPTH = 3,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [UINST_W-1:0]     in_uinst,
  input  logic [K_W-1:0]         in_k,
  input  logic                   flush,
  output logic                   flush_done,
  output logic [UINST_W-1:0]     out_uinst,
  output logic [K_W-1:0]         out_k,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  state_e                 state_q, state_d;
  logic                   flush_done_q, flush_done_d;
  logic [UINST_W-1:0]     out_uinst_q, out_uinst_d;
  logic [K_W-1:0]         out_k_q, out_k_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic hazard;
  logic sb_empty;
  logic sb_empty_next;
  logic issue;
  logic stall_event;

  // Carry is forwarded inside the datapath, so only register sources are tracked.
  ev21g1_scoreboard #(
    .DEPTH (HAZARD_DEPTH)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_valid_i (issue && has_dest(in_uinst)),
    .load_dest_i  (in_uinst[C_MSB:C_LSB]),
    .src_a_i      (in_uinst[A_MSB:A_LSB]),
    .a_used_i     (reads_a(in_uinst)),
    .src_b_i      (in_uinst[B_MSB:B_LSB]),
    .b_used_i     (reads_b(in_uinst)),
    .hazard_o     (hazard),
    .empty_o      (sb_empty),
    .empty_next_o (sb_empty_next)
  );

  // Gated by rst_n so nothing is accepted while reset is held.
  assign in_ready    = rst_n && (state_q == ST_RUN) && !flush && !hazard;
  assign issue       = in_valid && in_ready;
  assign stall_event = in_valid && !in_ready && hazard && (state_q == ST_RUN);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (flush) state_d = ST_DRAIN;
      ST_DRAIN: if (sb_empty) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase

    // Registered one cycle early: the pulse lands on the first DRAIN cycle with an empty board.
    flush_done_d = (state_d == ST_DRAIN) && sb_empty_next;

    out_uinst_d = issue ? in_uinst : NOP_WORD;
    out_k_d     = issue ? in_k : '0;

    stall_cnt_d = stall_cnt_q;
    if (stall_event && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      flush_done_q <= 1'b0;
      out_uinst_q  <= NOP_WORD;
      out_k_q      <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      flush_done_q <= flush_done_d;
      out_uinst_q  <= out_uinst_d;
      out_k_q      <= out_k_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign flush_done = flush_done_q;
  assign out_uinst  = out_uinst_q;
  assign out_k      = out_k_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_ev21g1_issue_ctrl.sv
// Self-checking bench for ev21g1_issue_ctrl: directed vector table, hand-written
// flush/reset sequences and randomized traffic against a timestamp-based model.
module tb_ev21g1_issue_ctrl;

  localparam int HD  = 3;
  localparam int SCW = 6;
  localparam int NV  = 28;
  localparam logic [29:0] NOP = 30'h000000FC;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [29:0]    in_uinst;
  logic [15:0]    in_k;
  logic           flush;
  logic           flush_done;
  logic [29:0]    out_uinst;
  logic [15:0]    out_k;
  logic [SCW-1:0] stall_cnt;

  always #5 clk = ~clk;

  ev21g1_issue_ctrl #(
    .HAZARD_DEPTH (HD),
    .STALL_CNT_W  (SCW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_uinst   (in_uinst),
    .in_k       (in_k),
    .flush      (flush),
    .flush_done (flush_done),
    .out_uinst  (out_uinst),
    .out_k      (out_k),
    .stall_cnt  (stall_cnt)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [29:0] mk(input logic [3:0] aluc, input logic kmx,
                                     input int a, input int b, input int c);
    return {aluc, 3'b000, kmx, 2'b00, 6'(a), 6'(b), 6'(c), 2'b00};
  endfunction

  // ---------------- reference model ----------------
  // lw[r] is the output cycle on which the latest write to r appeared; a reader
  // may only be accepted once that write is HD or more cycles old.
  int          n;
  int          lw [64];
  int          last_wr;
  bit          m_drain;
  int          m_stall;
  logic [29:0] m_out;
  logic [15:0] m_k;
  bit          m_hold;

  function automatic bit reads_a(input logic [29:0] u);
    return (u[22] == 1'b0) && (u[29:26] != 4'b1011) && (u[29:26] != 4'b1100);
  endfunction

  function automatic bit reads_b(input logic [29:0] u);
    logic [3:0] op;
    op = u[29:26];
    return (op == 4'b0001) || (op == 4'b0011) || (op == 4'b0100) ||
           (op == 4'b0101) || (op == 4'b0110) || (op == 4'b0111);
  endfunction

  function automatic bit busy(input int r);
    return (r != 63) && (lw[r] > n - HD);
  endfunction

  function automatic bit m_hz();
    return (reads_a(in_uinst) && busy(int'(in_uinst[19:14]))) ||
           (reads_b(in_uinst) && busy(int'(in_uinst[13:8])));
  endfunction

  function automatic bit m_empty();
    return last_wr <= n - HD;
  endfunction

  function automatic bit m_rdy();
    return !m_drain && !flush && !m_hz();
  endfunction

  task automatic init_model();
    n       = 0;
    last_wr = -100;
    for (int r = 0; r < 64; r++) lw[r] = -100;
    m_drain = 1'b0;
    m_stall = 0;
    m_out   = NOP;
    m_k     = '0;
    m_hold  = 1'b0;
  endtask

  task automatic check_model();
    check("model in_ready",   32'(in_ready),   32'(m_rdy()));
    check("model flush_done", 32'(flush_done), 32'(m_drain && m_empty()));
    check("model out_uinst",  32'(out_uinst),  32'(m_out));
    check("model out_k",      32'(out_k),      32'(m_k));
    check("model stall_cnt",  32'(stall_cnt),  32'(m_stall));
  endtask

  task automatic advance();
    bit hz, rdy, emp, was_drain;
    @(posedge clk);
    hz        = m_hz();
    rdy       = m_rdy();
    emp       = m_empty();
    was_drain = m_drain;
    if (m_drain) begin
      if (emp) m_drain = 1'b0;
    end else if (flush) begin
      m_drain = 1'b1;
    end
    if (in_valid && rdy) begin
      m_out = in_uinst;
      m_k   = in_k;
      if (in_uinst[7:2] != 6'd63) begin
        lw[int'(in_uinst[7:2])] = n + 1;
        last_wr                 = n + 1;
      end
    end else begin
      m_out = NOP;
      m_k   = '0;
    end
    if (in_valid && !rdy && hz && !was_drain && (m_stall < (1 << SCW) - 1)) m_stall++;
    m_hold = in_valid && !rdy;
    n++;
    #1;
  endtask

  function automatic logic [29:0] rand_uinst();
    logic [3:0]  op;
    logic [29:0] u;
    int          c;
    case ($urandom_range(0, 9))
      0: op = 4'b0000;
      1: op = 4'b0001;
      2: op = 4'b0011;
      3: op = 4'b0100;
      4: op = 4'b0101;
      5: op = 4'b0110;
      6: op = 4'b0111;
      7: op = 4'b1011;
      8: op = 4'b1100;
      default: op = 4'($urandom);
    endcase
    c = ($urandom_range(0, 4) == 0) ? 63 : int'($urandom_range(0, 7));
    u = mk(op, $urandom_range(0, 2) == 0, int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)), c);
    u[25:23] = 3'($urandom);
    u[21]    = 1'($urandom);
    u[20]    = 1'($urandom);
    u[1]     = 1'($urandom);
    u[0]     = 1'($urandom);
    return u;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        valid;
    logic [29:0] uinst;
    logic [15:0] k;
    logic        flush;
    logic        e_ready;
    logic [29:0] e_out;
    logic        e_done;
    int          e_stall;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mkv(input logic v, input logic [29:0] u, input logic [15:0] k,
                               input logic f, input logic er, input logic [29:0] eo,
                               input logic ed, input int es);
    vec_t r;
    r.valid   = v;
    r.uinst   = u;
    r.k       = k;
    r.flush   = f;
    r.e_ready = er;
    r.e_out   = eo;
    r.e_done  = ed;
    r.e_stall = es;
    return r;
  endfunction

  logic [29:0] idle_w, ld0, ld1, ld2, ld3, add_w, wr23, t3a, t3b, stc_w, adc_w, w5, w6;
  logic [29:0] ld7, dep7;

  initial begin
    idle_w = mk(4'b0000, 1'b1, 0, 0, 63);
    ld0    = mk(4'b0000, 1'b1, 0, 0, 0);
    ld1    = mk(4'b0000, 1'b1, 0, 0, 1);
    ld2    = mk(4'b0000, 1'b1, 0, 0, 2);
    ld3    = mk(4'b0000, 1'b1, 0, 0, 3);
    add_w  = mk(4'b0100, 1'b0, 3, 13, 20);
    wr23   = mk(4'b0000, 1'b1, 0, 0, 23);
    t3a    = mk(4'b0000, 1'b1, 23, 0, 30);
    t3b    = mk(4'b0110, 1'b1, 23, 23, 31);
    stc_w  = mk(4'b1100, 1'b0, 0, 0, 63);
    adc_w  = mk(4'b0101, 1'b0, 40, 41, 42);
    w5     = mk(4'b0000, 1'b1, 0, 0, 5);
    w6     = mk(4'b0000, 1'b1, 0, 0, 6);
    ld7    = mk(4'b0000, 1'b1, 0, 0, 7);
    dep7   = mk(4'b0100, 1'b0, 7, 9, 10);

    // independent K loads, back to back
    vecs[0]  = mkv(1, ld0,    16'h1111, 0, 1, NOP,   0, 0);
    vecs[1]  = mkv(1, ld1,    16'h2222, 0, 1, ld0,   0, 0);
    vecs[2]  = mkv(1, ld2,    16'h3333, 0, 1, ld1,   0, 0);
    vecs[3]  = mkv(0, idle_w, 16'h0000, 0, 1, ld2,   0, 0);
    // RAW on R3: three bubbles
    vecs[4]  = mkv(1, ld3,    16'h0033, 0, 1, NOP,   0, 0);
    vecs[5]  = mkv(1, add_w,  16'hA5A5, 0, 0, ld3,   0, 0);
    vecs[6]  = mkv(1, add_w,  16'hA5A5, 0, 0, NOP,   0, 1);
    vecs[7]  = mkv(1, add_w,  16'hA5A5, 0, 0, NOP,   0, 2);
    vecs[8]  = mkv(1, add_w,  16'hA5A5, 0, 1, NOP,   0, 3);
    vecs[9]  = mkv(0, idle_w, 16'h0000, 0, 1, add_w, 0, 3);
    // kmx=1 hides a; b=23 under OR does not
    vecs[10] = mkv(1, wr23,   16'h0023, 0, 1, NOP,   0, 3);
    vecs[11] = mkv(1, t3a,    16'h0300, 0, 1, wr23,  0, 3);
    vecs[12] = mkv(1, wr23,   16'h0023, 0, 1, t3a,   0, 3);
    vecs[13] = mkv(1, t3b,    16'h0301, 0, 0, wr23,  0, 3);
    vecs[14] = mkv(1, t3b,    16'h0301, 0, 0, NOP,   0, 4);
    vecs[15] = mkv(1, t3b,    16'h0301, 0, 0, NOP,   0, 5);
    vecs[16] = mkv(1, t3b,    16'h0301, 0, 1, NOP,   0, 6);
    vecs[17] = mkv(0, idle_w, 16'h0000, 0, 1, t3b,   0, 6);
    // STC then ADC: carry is forwarded, no bubble
    vecs[18] = mkv(1, stc_w,  16'h0000, 0, 1, NOP,   0, 6);
    vecs[19] = mkv(1, adc_w,  16'h5555, 0, 1, stc_w, 0, 6);
    vecs[20] = mkv(0, idle_w, 16'h0000, 0, 1, adc_w, 0, 6);
    // flush right after a write to R5, with W6 pending
    vecs[21] = mkv(1, w5,     16'h0005, 0, 1, NOP,   0, 6);
    vecs[22] = mkv(1, w6,     16'h0006, 1, 0, w5,    0, 6);
    vecs[23] = mkv(1, w6,     16'h0006, 0, 0, NOP,   0, 6);
    vecs[24] = mkv(1, w6,     16'h0006, 0, 0, NOP,   0, 6);
    vecs[25] = mkv(1, w6,     16'h0006, 0, 0, NOP,   1, 6);
    vecs[26] = mkv(1, w6,     16'h0006, 0, 1, NOP,   0, 6);
    vecs[27] = mkv(0, idle_w, 16'h0000, 0, 1, w6,    0, 6);

    // ---------------- reset state ----------------
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_uinst = idle_w;
    in_k     = 16'hFFFF;
    flush    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset in_ready",   32'(in_ready),   32'd0);
    check("reset out_uinst",  32'(out_uinst),  32'(NOP));
    check("reset out_k",      32'(out_k),      32'd0);
    check("reset flush_done", 32'(flush_done), 32'd0);
    check("reset stall_cnt",  32'(stall_cnt),  32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    init_model();

    // ---------------- table ----------------
    for (int i = 0; i < NV; i++) begin
      in_valid = vecs[i].valid;
      in_uinst = vecs[i].uinst;
      in_k     = vecs[i].k;
      flush    = vecs[i].flush;
      @(negedge clk);
      check($sformatf("vec%0d in_ready", i),   32'(in_ready),   32'(vecs[i].e_ready));
      check($sformatf("vec%0d out_uinst", i),  32'(out_uinst),  32'(vecs[i].e_out));
      check($sformatf("vec%0d flush_done", i), 32'(flush_done), 32'(vecs[i].e_done));
      check($sformatf("vec%0d stall_cnt", i),  32'(stall_cnt),  32'(vecs[i].e_stall));
      check_model();
      advance();
    end

    // ---------------- flush with an already-empty scoreboard ----------------
    in_valid = 1'b0;
    in_uinst = idle_w;
    in_k     = '0;
    flush    = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_model();
      advance();
    end
    flush = 1'b1;
    @(negedge clk);
    check("empty flush in_ready", 32'(in_ready),   32'd0);
    check("empty flush no pulse", 32'(flush_done), 32'd0);
    check_model();
    advance();
    flush = 1'b0;
    @(negedge clk);
    check("empty flush first drain pulse", 32'(flush_done), 32'd1);
    check("empty flush drain in_ready",    32'(in_ready),   32'd0);
    check_model();
    advance();
    @(negedge clk);
    check("empty flush pulse ends", 32'(flush_done), 32'd0);
    check("empty flush resume",     32'(in_ready),   32'd1);
    check_model();
    advance();

    // ---------------- reset during a hazard stall ----------------
    in_valid = 1'b1;
    in_uinst = ld7;
    in_k     = 16'h0007;
    @(negedge clk);
    check_model();
    advance();
    in_uinst = dep7;
    in_k     = 16'hBEEF;
    @(negedge clk);
    check("stall before reset", 32'(in_ready), 32'd0);
    check_model();
    advance();
    #1 rst_n = 1'b0;
    #1;
    check("async reset out_uinst", 32'(out_uinst), 32'(NOP));
    check("async reset out_k",     32'(out_k),     32'd0);
    check("async reset in_ready",  32'(in_ready),  32'd0);
    check("async reset stall_cnt", 32'(stall_cnt), 32'd0);
    init_model();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post reset in_ready", 32'(in_ready), 32'd1);
    check_model();
    advance();
    @(negedge clk);
    check("post reset issue", 32'(out_uinst), 32'(dep7));
    check("post reset k",     32'(out_k),     32'hBEEF);
    check_model();
    advance();

    // ---------------- randomized traffic ----------------
    for (int i = 0; i < 1500; i++) begin
      if (!m_hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_uinst = rand_uinst();
        in_k     = 16'($urandom);
      end
      flush = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      check_model();
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
